fetch_execute_buffer: RTL and testbench
=======================================

Name: fetch_execute_buffer

Overview:
- Parametrised, elastic successor to the plain fetch→execute signal bundle.
- A DEPTH-entry in-order queue of fetch packets {pc, instr, npc}, with a valid/ready handshake on each side and a pipeline flush.
- Decouples fetch stalls (I-cache miss) from execute stalls (hazards, D-cache miss).
- Sits between the fetch stage and the execute stage in the core pipeline.

Parameters:
- DEPTH, 2, number of buffered packets; power of two, ≥2.
- WORD_W, 32, width of pc, instr and npc.

Ports:
- CLK  in  1  core clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered packets (branch mispredict or exception redirect).
- f_valid  in  1  fetch presents a packet.
- f_ready  out  1  buffer accepts a packet this cycle.
- f_pc  in  WORD_W  fetched pc.
- f_instr  in  WORD_W  fetched instruction.
- f_npc  in  WORD_W  predicted next pc.
- e_valid  out  1  head packet available to execute.
- e_ready  in  1  execute consumes the head packet.
- e_pc  out  WORD_W  head pc.
- e_instr  out  WORD_W  head instruction.
- e_npc  out  WORD_W  head predicted next pc.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (nRST=0, asynchronous):
  - count=0; read and write pointers=0; all storage entries=0.
  - e_valid=0, f_ready=1, e_pc/e_instr/e_npc=0.
- Transfers:
  - enq = f_valid & f_ready.
  - deq = e_valid & e_ready.
  - Both take effect at the rising edge.
- Ready and valid:
  - f_ready = (count != DEPTH); it depends only on registered state.
  - There is no combinational path e_ready→f_ready, so a full buffer never accepts a packet in the same cycle as a dequeue.
  - e_valid = (count != 0).
- Output data:
  - e_pc/e_instr/e_npc = storage[rd_ptr].
  - Driven from registered state only; no f_*→e_* combinational path.
  - When e_valid=0 the outputs show the stale entry; execute must qualify them with e_valid.
- Latency: a packet enqueued at edge N is visible with e_valid=1 after edge N. Minimum fetch→execute latency is 1 cycle.
- Full throughput: with count in 1..DEPTH-1, simultaneous enq and deq leave count unchanged and both pointers advance.
- Occupancy update: count' = count + enq − deq.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap DEPTH-1→0 naturally; no sentinel bit is needed because count is tracked explicitly.
- Empty: deq is impossible (e_valid=0); e_ready is ignored.
- Full: enq is impossible (f_ready=0); f_valid is ignored.
- Flush:
  - Synchronous, evaluated at the edge.
  - count'=0 and rd_ptr'=wr_ptr'=0.
  - Any enq or deq in the flush cycle is discarded; flush dominates both.
  - Storage contents are not cleared.
  - In the cycle after flush: e_valid=0, f_ready=1.
- Order: strictly FIFO; packets are never reordered or duplicated.
- Reset during operation: asynchronous clear to the reset state regardless of handshake activity; no packet survives.

Optional Feature:
- Macro: FETCH_EXECUTE_BUFFER_PERF_EN.
- When defined, add output port starve_cnt (32 bits) and output port full_cnt (32 bits):
  - starve_cnt increments on every cycle with e_ready=1 & e_valid=0 & !flush.
  - full_cnt increments on every cycle with f_valid=1 & f_ready=0.
  - Both reset to 0 on nRST only (flush does not clear them).
  - Both saturate at 32'hFFFF_FFFF.
- When undefined, neither port nor their logic exists.
- Core behaviour is identical in both builds.

Decomposition:
- rv32i_types_pkg gains:
  - typedef fetch_packet_t, a packed struct {word_t pc; word_t instr; word_t npc;}.
  - constant FETCH_BUF_DEPTH_DEFAULT = 2.
- Storage is an array of fetch_packet_t.
- One natural sub-module, fetch_buffer_ctrl, holds the pointers, count, full/empty and flush logic and is reusable for other stage queues.
- The data array stays in the top level.

Test Plan:
- Reset, then f_valid=1 with pc=0x200, instr=0x00000013, npc=0x204 for one cycle → next cycle e_valid=1, e_pc=0x200, e_npc=0x204, count=1; e_ready=1 → count=0, e_valid=0.
- DEPTH=4: enqueue pc 0x0,0x4,0x8,0xC with e_ready=0 → count=4, f_ready=0; a fifth f_valid is dropped; dequeue order is 0x0,0x4,0x8,0xC.
- Streaming: f_valid=e_ready=1 for 20 cycles with pc incrementing by 4 → after the first cycle count stays 1; every pc appears once, in order, with 1-cycle latency.
- Wrap: 3×DEPTH enqueue/dequeue cycles with random e_ready (seed fixed) → scoreboard matches and pointers wrap with no loss.
- Flush with count=3 and f_valid=1 in the same cycle → next cycle count=0, e_valid=0, f_ready=1; the flushed-cycle packet never appears at e_*.
- nRST deasserted-then-asserted mid-stream with count=2 → outputs are immediately at reset values; with PERF_EN, holding e_ready=1 while empty for 5 cycles gives starve_cnt=5.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: shared pipeline types, including the fetch packet carried from fetch to execute.
package rv32i_types_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_BUF_DEPTH_DEFAULT = 2;
    typedef logic [XLEN-1:0] word_t;
    typedef struct packed {
        word_t pc;
        word_t instr;
        word_t npc;
    } fetch_packet_t;
endpackage

// File: rtl/fetch_buffer_ctrl.sv
// fetch_buffer_ctrl: pointer, occupancy and flush control for a small in-order stage queue.
module fetch_buffer_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    output logic                       ready,
    output logic                       valid,
    output logic                       enq,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    logic deq;
    assign ready = count != CW'(DEPTH);
    assign valid = count != '0;
    assign enq   = push & ready;
    assign deq   = pop & valid;
    // Flush dominates any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: rtl/fetch_execute_buffer.sv
// fetch_execute_buffer: elastic DEPTH-entry FIFO of fetch packets between fetch and execute.
// Define FETCH_EXECUTE_BUFFER_PERF_EN to add saturating starve_cnt/full_cnt counters.
module fetch_execute_buffer
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH  = FETCH_BUF_DEPTH_DEFAULT,
    parameter int WORD_W = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [WORD_W-1:0]          f_pc,
    input  logic [WORD_W-1:0]          f_instr,
    input  logic [WORD_W-1:0]          f_npc,
    output logic                       e_valid,
    input  logic                       e_ready,
    output logic [WORD_W-1:0]          e_pc,
    output logic [WORD_W-1:0]          e_instr,
    output logic [WORD_W-1:0]          e_npc,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_EXECUTE_BUFFER_PERF_EN
    ,
    output logic [31:0]                starve_cnt,
    output logic [31:0]                full_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          enq;
    fetch_packet_t mem [DEPTH];
    fetch_buffer_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk    (CLK),
        .rst_n  (nRST),
        .flush  (flush),
        .push   (f_valid),
        .pop    (e_ready),
        .ready  (f_ready),
        .valid  (e_valid),
        .enq    (enq),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count)
    );
    // Flush leaves storage intact; only the pointers are rewound.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq && !flush) begin
            mem[wr_ptr] <= '{pc: f_pc, instr: f_instr, npc: f_npc};
        end
    end
    assign e_pc    = mem[rd_ptr].pc;
    assign e_instr = mem[rd_ptr].instr;
    assign e_npc   = mem[rd_ptr].npc;
`ifdef FETCH_EXECUTE_BUFFER_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
            full_cnt   <= '0;
        end else begin
            starve_cnt <= (e_ready && !e_valid && !flush && starve_cnt != '1) ? starve_cnt + 1'b1 : starve_cnt;
            full_cnt   <= (f_valid && !f_ready && full_cnt != '1) ? full_cnt + 1'b1 : full_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_execute_buffer.sv
// tb_fetch_execute_buffer: directed self-checking bench for fetch_execute_buffer at DEPTH=4.
module tb_fetch_execute_buffer;
    localparam int DEPTH = 4;
    logic        CLK = 0, nRST = 0, flush = 0, f_valid = 0, e_ready = 0;
    logic [31:0] f_pc = 0, f_instr = 0, f_npc = 0;
    logic        f_ready, e_valid;
    logic [31:0] e_pc, e_instr, e_npc;
    logic [2:0]  count;
    int checks = 0, errors = 0;
`ifdef FETCH_EXECUTE_BUFFER_PERF_EN
    logic [31:0] starve_cnt, full_cnt;
`endif

    fetch_execute_buffer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_instr(f_instr), .f_npc(f_npc),
        .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_instr(e_instr), .e_npc(e_npc),
        .count(count)
`ifdef FETCH_EXECUTE_BUFFER_PERF_EN
        , .starve_cnt(starve_cnt), .full_cnt(full_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL reset_e_valid got %b exp 0", e_valid); end
        checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL reset_f_ready got %b exp 1", f_ready); end
        checks++; if (e_pc !== 32'h0) begin errors++; $display("FAIL reset_e_pc got %h exp 0", e_pc); end
        tick();
        nRST = 1;
    endtask

    task automatic test_single();
        f_valid = 1; f_pc = 32'h200; f_instr = 32'h13; f_npc = 32'h204;
        tick();
        f_valid = 0;
        checks++; if (e_valid !== 1'b1) begin errors++; $display("FAIL single_e_valid got %b exp 1", e_valid); end
        checks++; if (e_pc !== 32'h200) begin errors++; $display("FAIL single_e_pc got %h exp 200", e_pc); end
        checks++; if (e_instr !== 32'h13) begin errors++; $display("FAIL single_e_instr got %h exp 13", e_instr); end
        checks++; if (e_npc !== 32'h204) begin errors++; $display("FAIL single_e_npc got %h exp 204", e_npc); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        e_ready = 1;
        tick();
        e_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count got %0d exp 0", count); end
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL single_drain_e_valid got %b exp 0", e_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            f_valid = 1; f_pc = 32'(i * 4); f_instr = 32'(i); f_npc = 32'(i * 4 + 4);
            tick();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL fill_f_ready got %b exp 0", f_ready); end
        f_pc = 32'h10;
        tick();
        f_valid = 0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_drop_count got %0d exp 4", count); end
        e_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (e_valid !== 1'b1 || e_pc !== 32'(i * 4)) begin errors++; $display("FAIL fill_order[%0d] got v=%b pc=%h exp v=1 pc=%h", i, e_valid, e_pc, i * 4); end
            tick();
        end
        e_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty_count got %0d exp 0", count); end
    endtask

    task automatic test_stream();
        f_valid = 1; e_ready = 1;
        for (int i = 0; i < 20; i++) begin
            f_pc = 32'h1000 + 32'(i * 4); f_npc = f_pc + 4;
            tick();
            checks++; if (count !== 3'd1 || e_pc !== 32'h1000 + 32'(i * 4)) begin errors++; $display("FAIL stream[%0d] got cnt=%0d pc=%h exp cnt=1 pc=%h", i, count, e_pc, 32'h1000 + 32'(i * 4)); end
        end
        f_valid = 0;
        tick();
        e_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain got %0d exp 0", count); end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        int sent = 0, rcvd = 0, mc = 0, budget = 0;
        bit en, de;
        void'($urandom(32'd1234));
        while (rcvd < 3 * DEPTH && budget < 300) begin
            f_valid = sent < 3 * DEPTH;
            f_pc = 32'h3000 + 32'(sent * 4);
            e_ready = 1'($urandom_range(0, 1));
            en = f_valid && mc != DEPTH;
            de = e_ready && mc != 0;
            if (de) begin
                checks++; if (e_valid !== 1'b1 || e_pc !== q[0]) begin errors++; $display("FAIL wrap_data got v=%b pc=%h exp v=1 pc=%h", e_valid, e_pc, q[0]); end
                void'(q.pop_front());
                rcvd++;
            end
            if (en) begin
                q.push_back(f_pc);
                sent++;
            end
            mc = mc + int'(en) - int'(de);
            tick();
            checks++; if (count !== 3'(mc)) begin errors++; $display("FAIL wrap_count got %0d exp %0d", count, mc); end
            budget++;
        end
        f_valid = 0; e_ready = 0;
        checks++; if (rcvd != 3 * DEPTH) begin errors++; $display("FAIL wrap_timeout got %0d exp %0d", rcvd, 3 * DEPTH); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            f_valid = 1; f_pc = 32'h40 + 32'(i * 4);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
        flush = 1; f_pc = 32'hDEAD0;
        tick();
        flush = 0; f_valid = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL flush_e_valid got %b exp 0", e_valid); end
        checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL flush_f_ready got %b exp 1", f_ready); end
        f_valid = 1; f_pc = 32'h500;
        tick();
        f_valid = 0;
        checks++; if (count !== 3'd1 || e_pc !== 32'h500) begin errors++; $display("FAIL flush_next got cnt=%0d pc=%h exp cnt=1 pc=500", count, e_pc); end
        e_ready = 1;
        tick();
        e_ready = 0;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL flush_only_one got %b exp 0", e_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            f_valid = 1; f_pc = 32'h700 + 32'(i * 4);
            tick();
        end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_pre_count got %0d exp 2", count); end
        #3 nRST = 0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL rmid_e_valid got %b exp 0", e_valid); end
        checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL rmid_f_ready got %b exp 1", f_ready); end
        checks++; if (e_pc !== 32'h0) begin errors++; $display("FAIL rmid_e_pc got %h exp 0", e_pc); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_hold_count got %0d exp 0", count); end
        f_valid = 0;
        nRST = 1;
    endtask

`ifdef FETCH_EXECUTE_BUFFER_PERF_EN
    task automatic test_perf();
        e_ready = 1;
        for (int i = 0; i < 5; i++) tick();
        e_ready = 0;
        checks++; if (starve_cnt !== 32'd5) begin errors++; $display("FAIL perf_starve got %0d exp 5", starve_cnt); end
        checks++; if (full_cnt !== 32'd0) begin errors++; $display("FAIL perf_full got %0d exp 0", full_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_wrap();
        test_flush();
        test_reset_mid();
`ifdef FETCH_EXECUTE_BUFFER_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
